// File: rtl/compare_sequencer_if.sv
// Handshake and comparator-side signal bundle for compare_sequencer.
// The slave modport is the sequencer's view. The master modport is the view of
// the environment that feeds operands, models the comparator and drains results.
interface compare_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_load;
  logic             cmp_clr;
  logic             cmp_op;
  logic             cmp_L;
  logic             cmp_E;
  logic             cmp_G;
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             eq;
  logic             gt;
  logic             err;
  logic             busy;

  modport slave (
    input  in_valid, a_in, b_in, cmp_L, cmp_E, cmp_G, out_ready,
    output in_ready, cmp_a, cmp_b, cmp_load, cmp_clr, cmp_op,
           out_valid, lt, eq, gt, err, busy
  );

  modport master (
    output in_valid, a_in, b_in, cmp_L, cmp_E, cmp_G, out_ready,
    input  in_ready, cmp_a, cmp_b, cmp_load, cmp_clr, cmp_op,
           out_valid, lt, eq, gt, err, busy
  );
endinterface

// File: rtl/compare_sequencer.sv
// Sequencer for a serial magnitude comparator. It accepts one operand pair and
// loads the comparator. It then runs the comparator for WIDTH shift cycles,
// captures the L/E/G flags and presents the result until it is taken.
//
// state   | meaning
// IDLE    | waiting for an operand pair
// LOAD    | parallel-load and clear the comparator (one cycle)
// RUN     | comparator shifting, WIDTH cycles
// CAPTURE | register comparator flags, check they are one-hot
// DONE    | result valid, waiting for consumer
module compare_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               res,
  compare_sequencer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_lt;
  logic             r_eq;
  logic             r_gt;
  logic             r_err;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_onehot;

  // A finished result can be replaced in the same cycle it is taken.
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_onehot   = ( bus.cmp_L && !bus.cmp_E && !bus.cmp_G) ||
                      (!bus.cmp_L &&  bus.cmp_E && !bus.cmp_G) ||
                      (!bus.cmp_L && !bus.cmp_E &&  bus.cmp_G);

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_LOAD;
      S_LOAD:    w_next = S_RUN;
      S_RUN:     if (r_cnt == LAST) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_DONE;
      S_DONE:    if (bus.out_ready) w_next = bus.in_valid ? S_LOAD : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge res) begin
    if (res) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Shift-cycle counter: cleared in LOAD so RUN always starts from 0.
  always_ff @(posedge clk or posedge res) begin
    if (res)                   r_cnt <= '0;
    else if (r_state == S_LOAD) r_cnt <= '0;
    else if (r_state == S_RUN)  r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

  // Operand registers only move on an accepted handshake.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_accept) begin
      r_a <= bus.a_in;
      r_b <= bus.b_in;
    end
  end

  // Result registers update only in CAPTURE and hold across the handshake.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_lt  <= 1'b0;
      r_eq  <= 1'b0;
      r_gt  <= 1'b0;
      r_err <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_lt  <= bus.cmp_L;
      r_eq  <= bus.cmp_E;
      r_gt  <= bus.cmp_G;
      r_err <= !w_onehot;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.cmp_a     = r_a;
  assign bus.cmp_b     = r_b;
  assign bus.cmp_load  = (r_state == S_LOAD);
  assign bus.cmp_clr   = (r_state == S_LOAD);
  assign bus.cmp_op    = (r_state == S_RUN);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.lt        = r_lt;
  assign bus.eq        = r_eq;
  assign bus.gt        = r_gt;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state != S_IDLE);
endmodule
